md5_avalon_bridge: RTL and testbench

Avalon-MM slave that the HPS lightweight bridge uses to drive the `md5group` cracker array. It is the responder side of the `md5_input_*`, `md5_output_*` and `md5_control_*` conduits. It converts word-addressed bus writes and reads into:
- message-word writes into the array,
- multicycle result reads out of the array,
- one-cycle start/reset pulses,
- a sticky per-unit done status.

---
 rtl/md5_avalon_bridge_if.sv | 20 ++
 rtl/md5_avalon_bridge.sv | 109 ++++++++++
 tb/tb_md5_avalon_bridge.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/md5_avalon_bridge_if.sv
// Avalon-MM word-addressed bus between the HPS lightweight bridge and the
// md5 cracker bridge.
interface md5_avalon_bridge_if;
   logic [9:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/md5_avalon_bridge.sv
// Avalon-MM slave that turns bus accesses into md5 array message writes,
// multicycle result reads, start/reset pulses and a sticky done status.
module md5_avalon_bridge #(
   parameter int NUNITS = 32
) (
   input  logic              clk,
   input  logic              reset,
   md5_avalon_bridge_if.slave avs,
   output logic [31:0]       md5_input_data,
   output logic [8:0]        md5_input_addr,
   output logic              md5_input_write,
   output logic [6:0]        md5_output_readaddr,
   input  logic [31:0]       md5_output_readdata,
   output logic [NUNITS-1:0] md5_control_start,
   output logic [NUNITS-1:0] md5_control_reset,
   input  logic [NUNITS-1:0] md5_control_done
);

   localparam logic [9:0] ADDR_START = 10'h280;
   localparam logic [9:0] ADDR_RESET = 10'h281;
   localparam logic [9:0] ADDR_DONE  = 10'h282;
   localparam logic [9:0] ADDR_LIVE  = 10'h283;

   typedef enum logic [1:0] {IDLE, RD_ADDR, RD_WAIT, RD_DONE} state_t;

   state_t            state;
   logic [NUNITS-1:0] done_p1;
   logic [NUNITS-1:0] sticky_done;
   logic [NUNITS-1:0] done_set;
   logic [NUNITS-1:0] done_clr;
   logic              msg_wr;
   logic              start_wr;
   logic              unit_rst_wr;
   logic              result_rd;
   logic [31:0]       status;

   always_comb begin
      msg_wr      = avs.avs_write && !avs.avs_address[9];
      start_wr    = avs.avs_write && (avs.avs_address == ADDR_START);
      unit_rst_wr = avs.avs_write && (avs.avs_address == ADDR_RESET);
      result_rd   = (avs.avs_address[9:7] == 3'b100);
      done_set    = md5_control_done & ~done_p1;
      // Clear is taken from the accepting cycle so it beats a coincident edge
      done_clr    = {NUNITS{start_wr | unit_rst_wr}} & avs.avs_writedata[NUNITS-1:0];
      status      = '0;
      case (avs.avs_address)
         ADDR_DONE: status = 32'(sticky_done);
         ADDR_LIVE: status = 32'(md5_control_done);
         default:   status = '0;
      endcase
   end

   assign avs.avs_waitrequest = avs.avs_read && (state != RD_DONE);

   // Write path: strobes and data registered one cycle after acceptance
   always_ff @(posedge clk) begin
      if (reset) begin
         md5_input_write   <= 1'b0;
         md5_input_addr    <= '0;
         md5_input_data    <= '0;
         md5_control_start <= '0;
         md5_control_reset <= '0;
         done_p1           <= '0;
         sticky_done       <= '0;
      end else begin
         md5_input_write <= msg_wr;
         if (msg_wr) begin
            md5_input_addr <= avs.avs_address[8:0];
            md5_input_data <= avs.avs_writedata;
         end
         md5_control_start <= start_wr    ? avs.avs_writedata[NUNITS-1:0] : '0;
         md5_control_reset <= unit_rst_wr ? avs.avs_writedata[NUNITS-1:0] : '0;
         done_p1           <= md5_control_done;
         sticky_done       <= (sticky_done | done_set) & ~done_clr;
      end
   end

   // Read FSM: avs_readdata doubles as the holding register, nonzero only in RD_DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         md5_output_readaddr <= '0;
         avs.avs_readdata    <= '0;
      end else begin
         avs.avs_readdata <= '0;
         case (state)
            IDLE: begin
               if (avs.avs_read && !avs.avs_write) begin
                  if (result_rd) begin
                     md5_output_readaddr <= avs.avs_address[6:0];
                     state               <= RD_ADDR;
                  end else begin
                     avs.avs_readdata <= status;
                     state            <= RD_DONE;
                  end
               end
            end
            RD_ADDR: state <= RD_WAIT;
            RD_WAIT: begin
               avs.avs_readdata <= md5_output_readdata;
               state            <= RD_DONE;
            end
            RD_DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_avalon_bridge.sv
// Directed bench for md5_avalon_bridge with a scoreboard queue of expected
// read data and a registered model of the result array.
module tb_md5_avalon_bridge;
   localparam int NUNITS = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       md5_input_data;
   logic [8:0]        md5_input_addr;
   logic              md5_input_write;
   logic [6:0]        md5_output_readaddr;
   logic [31:0]       md5_output_readdata;
   logic [NUNITS-1:0] md5_control_start;
   logic [NUNITS-1:0] md5_control_reset;
   logic [NUNITS-1:0] done_in;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   md5_avalon_bridge_if bus ();

   md5_avalon_bridge #(.NUNITS(NUNITS)) dut (
      .clk                 (clk),
      .reset               (reset),
      .avs                 (bus),
      .md5_input_data      (md5_input_data),
      .md5_input_addr      (md5_input_addr),
      .md5_input_write     (md5_input_write),
      .md5_output_readaddr (md5_output_readaddr),
      .md5_output_readdata (md5_output_readdata),
      .md5_control_start   (md5_control_start),
      .md5_control_reset   (md5_control_reset),
      .md5_control_done    (done_in)
   );

   // Result array model: word = {readaddr, 25'h0}, one cycle behind readaddr
   always_ff @(posedge clk) md5_output_readdata <= {md5_output_readaddr, 25'h0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Read already presented; count wait cycles, then compare against the scoreboard
   task automatic wait_read(input logic [9:0] addr, input int exp_waits);
      int          waits = 0;
      bit          done  = 1'b0;
      logic [31:0] e;
      for (int i = 0; i < 16 && !done; i++) begin
         #1;
         if (bus.avs_waitrequest) begin
            if (waits == 1 && addr[9:7] == 3'b100)
               chk("rd_readaddr", 32'(md5_output_readaddr), 32'(addr[6:0]));
            waits++;
            @(negedge clk);
         end else begin
            done = 1'b1;
            e    = sb_q.pop_front();
            chk("rd_data", bus.avs_readdata, e);
         end
      end
      chk("rd_complete", 32'(done), 32'd1);
      chk("rd_waits", 32'(waits), 32'(exp_waits));
      if (!done) sb_q.delete();
      @(posedge clk);
      #1 bus.avs_read = 1'b0;
   endtask

   task automatic do_read(input logic [9:0] addr, input logic [31:0] exp, input int exp_waits);
      @(negedge clk);
      bus.avs_address = addr;
      bus.avs_read    = 1'b1;
      sb_q.push_back(exp);
      wait_read(addr, exp_waits);
   endtask

   // Returns in the low phase of the cycle after acceptance
   task automatic do_write(input logic [9:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.avs_address   = addr;
      bus.avs_writedata = data;
      bus.avs_write     = 1'b1;
      #1 chk("wr_nowait", 32'(bus.avs_waitrequest), 32'd0);
      @(negedge clk);
      bus.avs_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.avs_address   = '0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      done_in           = '0;
      reset             = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_input_write", 32'(md5_input_write), 32'd0);
      chk("rst_input_addr", 32'(md5_input_addr), 32'd0);
      chk("rst_input_data", md5_input_data, 32'd0);
      chk("rst_readaddr", 32'(md5_output_readaddr), 32'd0);
      chk("rst_start", md5_control_start, 32'd0);
      chk("rst_unit_reset", md5_control_reset, 32'd0);
      chk("rst_readdata", bus.avs_readdata, 32'd0);
      chk("rst_waitrequest", 32'(bus.avs_waitrequest), 32'd0);
      reset = 1'b0;

      // Single message write
      do_write(10'h005, 32'hDEADBEEF);
      chk("msg_strobe", 32'(md5_input_write), 32'd1);
      chk("msg_addr", 32'(md5_input_addr), 32'h5);
      chk("msg_data", md5_input_data, 32'hDEADBEEF);
      chk("msg_no_start", md5_control_start, 32'd0);
      @(negedge clk);
      chk("msg_strobe_end", 32'(md5_input_write), 32'd0);
      chk("msg_addr_hold", 32'(md5_input_addr), 32'h5);

      // Back-to-back message writes
      @(negedge clk);
      bus.avs_address = 10'h1FF; bus.avs_writedata = 32'h10; bus.avs_write = 1'b1;
      @(negedge clk);
      chk("b2b_strobe0", 32'(md5_input_write), 32'd1);
      chk("b2b_addr0", 32'(md5_input_addr), 32'h1FF);
      chk("b2b_data0", md5_input_data, 32'h10);
      bus.avs_address = 10'h001; bus.avs_writedata = 32'h20;
      @(negedge clk);
      bus.avs_write = 1'b0;
      chk("b2b_strobe1", 32'(md5_input_write), 32'd1);
      chk("b2b_addr1", 32'(md5_input_addr), 32'h1);
      chk("b2b_data1", md5_input_data, 32'h20);
      @(negedge clk);
      chk("b2b_strobe_end", 32'(md5_input_write), 32'd0);

      // Result read
      do_read(10'h213, 32'h26000000, 3);

      // Sticky and live done
      @(negedge clk); done_in = 32'h5;
      repeat (2) @(negedge clk);
      do_read(10'h282, 32'h5, 1);
      do_read(10'h283, 32'h5, 1);

      do_write(10'h280, 32'h5);
      chk("start_pulse", md5_control_start, 32'h5);
      chk("start_no_reset", md5_control_reset, 32'h0);
      @(negedge clk);
      chk("start_pulse_end", md5_control_start, 32'h0);
      do_read(10'h282, 32'h0, 1);

      @(negedge clk); done_in = 32'hD;
      do_read(10'h282, 32'h8, 1);
      do_write(10'h281, 32'h8);
      chk("ureset_pulse", md5_control_reset, 32'h8);
      @(negedge clk);
      chk("ureset_pulse_end", md5_control_reset, 32'h0);
      do_read(10'h282, 32'h0, 1);
      do_read(10'h283, 32'hD, 1);

      // Edge of done[1] coincides with the START write that clears it
      @(negedge clk);
      done_in = 32'hF;
      bus.avs_address = 10'h280; bus.avs_writedata = 32'h2; bus.avs_write = 1'b1;
      @(negedge clk);
      bus.avs_write = 1'b0;
      chk("clr_wins_start", md5_control_start, 32'h2);
      do_read(10'h282, 32'h0, 1);
      @(negedge clk); done_in = 32'hD;
      @(negedge clk); done_in = 32'hF;
      do_read(10'h282, 32'h2, 1);

      // Reset during RD_WAIT, read restarts after release
      @(negedge clk);
      bus.avs_address = 10'h205; bus.avs_read = 1'b1;
      sb_q.push_back(32'h0A000000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_wait", 32'(bus.avs_waitrequest), 32'd1);
      chk("midrst_readdata", bus.avs_readdata, 32'd0);
      chk("midrst_readaddr", 32'(md5_output_readaddr), 32'd0);
      chk("midrst_input_addr", 32'(md5_input_addr), 32'd0);
      reset = 1'b0;
      wait_read(10'h205, 3);
      do_read(10'h282, 32'hF, 1);

      // Unmapped and write-only space reads
      do_read(10'h3FF, 32'h0, 1);
      do_read(10'h100, 32'h0, 1);

      // Unmapped write is ignored
      do_write(10'h3FF, 32'hFFFFFFFF);
      chk("unmapped_no_msg", 32'(md5_input_write), 32'd0);
      chk("unmapped_no_start", md5_control_start, 32'd0);
      chk("unmapped_no_ureset", md5_control_reset, 32'd0);
      chk("unmapped_data_hold", md5_input_data, 32'd0);

      // Read and write together: write performed, read held until write drops
      @(negedge clk);
      bus.avs_address = 10'h007; bus.avs_writedata = 32'h1234;
      bus.avs_write = 1'b1; bus.avs_read = 1'b1;
      sb_q.push_back(32'h0);
      #1 chk("rw_wait0", 32'(bus.avs_waitrequest), 32'd1);
      @(negedge clk);
      chk("rw_strobe", 32'(md5_input_write), 32'd1);
      chk("rw_addr", 32'(md5_input_addr), 32'h7);
      chk("rw_data", md5_input_data, 32'h1234);
      chk("rw_readdata_idle", bus.avs_readdata, 32'd0);
      bus.avs_write = 1'b0;
      wait_read(10'h007, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
